// File: rtl/cp0_int_unit.sv
// Coprocessor-0 interrupt unit: synchronises IRQ lines, latches pending requests,
// and commits IE/IRS/EPC writes through a short pipeline aligned with writeback.
module cp0_int_unit #(
  parameter int   PC_W       = 32,
  parameter int   COMMIT_LAT = 2,
  parameter logic IE_RESET   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      irq_in,
  input  logic            inting,
  input  logic [3:0]      cp0_w_en,
  input  logic [3:0]      cp0_w_data,
  input  logic            bubble,
  input  logic [PC_W-1:0] epc_in,
  output logic            int_req,   // "int" is a reserved word in SystemVerilog
  output logic [2:0]      ints,
  output logic [2:0]      irs,
  output logic            ie,
  output logic [PC_W-1:0] epc,
  output logic [2:0]      pending,
  output logic            cp0_w_collision
);

  localparam int LAST = COMMIT_LAT - 1;

  // Blocks every source at or below the highest in-service level.
  function automatic logic [2:0] lower_mask(input logic [2:0] level);
    if (level[2])      return 3'b111;
    else if (level[1]) return 3'b011;
    else if (level[0]) return 3'b001;
    else               return 3'b000;
  endfunction

  function automatic logic [2:0] encode_winner(input logic [2:0] elig);
    if (elig[2])      return 3'd3;
    else if (elig[1]) return 3'd2;
    else if (elig[0]) return 3'd1;
    else              return 3'd0;
  endfunction

  logic [2:0] irq_p0, irq_p1, irq_p2;
  logic [2:0] irq_rise;

  // Stage: two-flop synchroniser followed by the edge register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_p0 <= '0;
      irq_p1 <= '0;
      irq_p2 <= '0;
    end else begin
      irq_p0 <= irq_in;
      irq_p1 <= irq_p0;
      irq_p2 <= irq_p1;
    end
  end

  assign irq_rise = irq_p1 & ~irq_p2;

  logic                            accept;
  logic [COMMIT_LAT-1:0]           vld_p;
  logic [COMMIT_LAT-1:0][3:0]      en_p;
  logic [COMMIT_LAT-1:0][3:0]      data_p;
  logic [COMMIT_LAT-1:0][PC_W-1:0] epc_p;

  assign accept = inting && (|cp0_w_en) && !bubble;

  // Stage: commit pipeline, entry commits when it reaches the last slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < COMMIT_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    en_p[0]   <= cp0_w_en;
    data_p[0] <= cp0_w_data;
    epc_p[0]  <= epc_in;
    for (int i = 1; i < COMMIT_LAT; i++) begin
      en_p[i]   <= en_p[i-1];
      data_p[i] <= data_p[i-1];
      epc_p[i]  <= epc_p[i-1];
    end
  end

  logic       cm_vld;
  logic [3:0] cm_en;
  logic [2:0] cm_mask;
  logic [2:0] set_mask;
  logic [2:0] irs_next;

  assign cm_vld   = vld_p[LAST];
  assign cm_en    = en_p[LAST];
  assign cm_mask  = data_p[LAST][3:1];
  assign set_mask = (cm_vld && cm_en[3]) ? cm_mask : 3'b000;

  // Clear (keep-mask) first, then set, so a combined entry ends with the set bits present.
  always_comb begin
    irs_next = irs;
    if (cm_vld && cm_en[2]) irs_next = irs_next & cm_mask;
    if (cm_vld && cm_en[3]) irs_next = irs_next | cm_mask;
  end

  // Stage: architectural state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      irs     <= '0;
      ie      <= IE_RESET;
      epc     <= '0;
    end else begin
      pending <= (pending & ~set_mask) | irq_rise;
      irs     <= irs_next;
      if (cm_vld && cm_en[1]) ie  <= data_p[LAST][0];
      if (cm_vld && cm_en[0]) epc <= epc_p[LAST];
    end
  end

  logic [2:0] eligible;

  assign eligible        = pending & ~lower_mask(irs);
  assign ints            = encode_winner(eligible);
  assign int_req         = ie && (|eligible);
  assign cp0_w_collision = |vld_p;

endmodule
